osl_tx_arbiter: RTL

//  Round-robin arbiter sharing the single transmit host port (host_wr/host_din/host_dir) of one
//  osl_rxtx link endpoint among NREQ local requesters. It captures one word from the winning

---
 rtl/osl_tx_arbiter_pkg.sv | 19 +
 rtl/osl_tx_arbiter_if.sv | 30 +++
 rtl/osl_tx_arbiter_rr_pick.sv | 26 ++
 rtl/osl_tx_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/osl_tx_arbiter_pkg.sv
// Shared types and defaults for the osl_rxtx transmit-port arbiter.
// State encodings are fixed 2-bit values so they line up with the link headers.
package osl_tx_arbiter_pkg;

    localparam int TXA_WORDSZ = 32;
    localparam int TXA_TMO    = 64;

    typedef enum logic [1:0] {
        TXA_IDLE     = 2'd0,
        TXA_WRITE    = 2'd1,
        TXA_WAIT_LOW = 2'd2
    } txa_state_e;

    // Index reached by stepping 'off' places past 'base' on a ring of 'n' entries.
    function automatic int txa_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/osl_tx_arbiter_if.sv
// Requester and host-port bundle between the arbiter (master) and its environment (slave).
interface osl_tx_arbiter_if
    import osl_tx_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int GIDW   = 2,
    parameter int WORDSZ = TXA_WORDSZ
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*WORDSZ-1:0] req_data;
    logic [NREQ-1:0]        req_ack;
    logic                   host_wr;
    logic [WORDSZ-1:0]      host_din;
    logic                   host_dir;
    logic                   busy;
    logic [GIDW-1:0]        grant_id;
    logic                   timeout_err;
    logic                   err_clr;

    modport master (
        input  req_valid, req_data, host_dir, err_clr,
        output req_ack, host_wr, host_din, busy, grant_id, timeout_err
    );

    modport slave (
        output req_valid, req_data, host_dir, err_clr,
        input  req_ack, host_wr, host_din, busy, grant_id, timeout_err
    );

endinterface

// File: rtl/osl_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after the last winner, with wrap.
module osl_rr_pick
    import osl_tx_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GIDW = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [GIDW-1:0] i_last,
    output logic [GIDW-1:0] o_win,
    output logic            o_found
);

    // Offsets run 1..NREQ so the last winner is considered only after everyone else.
    always_comb begin
        o_win   = '0;
        o_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!o_found && i_req[GIDW'(txa_wrap(int'(i_last), k, NREQ))]) begin
                o_win   = GIDW'(txa_wrap(int'(i_last), k, NREQ));
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/osl_tx_arbiter.sv
// Round-robin arbiter feeding one word at a time into the osl_rxtx transmit host port,
// then holding off until the link has gone busy (host_dir low) or a timeout expires.
module osl_tx_arbiter
    import osl_tx_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int GIDW   = 2,
    parameter int TMO    = TXA_TMO,
    parameter int WORDSZ = TXA_WORDSZ
) (
    input  logic              clk,
    input  logic              reset,
    osl_tx_arbiter_if.master  bus
);

    localparam int              CNTW     = $clog2(TMO);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TMO - 1);

    txa_state_e        r_state;
    txa_state_e        w_state_nxt;
    logic              w_grant;
    logic              w_tmo;
    logic [GIDW-1:0]   w_win;
    logic              w_found;
    logic [NREQ-1:0]   w_onehot;
    logic [WORDSZ-1:0] w_word;

    logic [GIDW-1:0]   r_last;
    logic [CNTW-1:0]   r_cnt;
    logic [NREQ-1:0]   r_req_ack;
    logic              r_host_wr;
    logic [WORDSZ-1:0] r_host_din;
    logic              r_busy;
    logic [GIDW-1:0]   r_grant_id;
    logic              r_timeout_err;

    osl_rr_pick #(
        .NREQ (NREQ),
        .GIDW (GIDW)
    ) u_pick (
        .i_req   (bus.req_valid),
        .i_last  (r_last),
        .o_win   (w_win),
        .o_found (w_found)
    );

    always_comb begin
        w_onehot = '0;
        w_word   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == GIDW'(i)) begin
                w_onehot[i] = 1'b1;
                w_word      = bus.req_data[i*WORDSZ +: WORDSZ];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= TXA_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Requests are only looked at in IDLE and only while the link reports TX ready.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            TXA_IDLE: begin
                if (bus.host_dir && w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = TXA_WRITE;
                end
            end
            TXA_WRITE: begin
                w_state_nxt = TXA_WAIT_LOW;
            end
            TXA_WAIT_LOW: begin
                if (!bus.host_dir) begin
                    w_state_nxt = TXA_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = TXA_IDLE;
                end
            end
            default: begin
                w_state_nxt = TXA_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state decode so host_wr/req_ack land in the WRITE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last        <= GIDW'(NREQ - 1);
            r_cnt         <= '0;
            r_req_ack     <= '0;
            r_host_wr     <= 1'b0;
            r_host_din    <= '0;
            r_busy        <= 1'b0;
            r_grant_id    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_host_wr <= w_grant;
            r_req_ack <= w_grant ? w_onehot : '0;
            r_busy    <= (w_state_nxt != TXA_IDLE);
            if (w_grant) begin
                r_host_din <= w_word;
                r_grant_id <= w_win;
                r_last     <= w_win;
            end
            if (r_state == TXA_WRITE) begin
                r_cnt <= '0;
            end else if (r_state == TXA_WAIT_LOW) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (bus.err_clr) begin
                r_timeout_err <= 1'b0;
            end else if (w_tmo) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign bus.req_ack     = r_req_ack;
    assign bus.host_wr     = r_host_wr;
    assign bus.host_din    = r_host_din;
    assign bus.busy        = r_busy;
    assign bus.grant_id    = r_grant_id;
    assign bus.timeout_err = r_timeout_err;

endmodule
